// File: rtl/ssd_scan_ctrl.sv
// N-digit multiplexed seven-segment scanner with frame-synchronous data update; SSD_SCAN_DIM_EN adds bright_i dimming.
// Latency: anode/seg/dp_n are registered, one clk behind digit_sel/prescaler.
// Backpressure: none; upd_i is buffered one deep in staging, last request before the frame boundary wins.
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 2,
    parameter int SELW        = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic                    upd_i,
`ifdef SSD_SCAN_DIM_EN
    input  logic [3:0]              bright_i,
`endif
    output logic                    upd_pending_o,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [SELW-1:0]         digit_sel,
    output logic                    frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0]           presc_q, presc_d;
    logic [SELW-1:0]         sel_q, sel_d;
    logic                    fd_q, fd_d;
    logic                    pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0] stg_dig_q, stg_dig_d, shd_dig_q, shd_dig_d;
    logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
    logic [NUM_DIGITS-1:0]   stg_blk_q, stg_blk_d, shd_blk_q, shd_blk_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dpn_q, dpn_d;
    logic                    tick, last, wrap, lit;
    logic [3:0]              nib;
`ifdef SSD_SCAN_DIM_EN
    logic [3:0]              bright_q, bright_d;
`endif

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0: hex2seg = 7'h40;
            4'h1: hex2seg = 7'h79;
            4'h2: hex2seg = 7'h24;
            4'h3: hex2seg = 7'h30;
            4'h4: hex2seg = 7'h19;
            4'h5: hex2seg = 7'h12;
            4'h6: hex2seg = 7'h02;
            4'h7: hex2seg = 7'h78;
            4'h8: hex2seg = 7'h00;
            4'h9: hex2seg = 7'h10;
            4'hA: hex2seg = 7'h08;
            4'hB: hex2seg = 7'h03;
            4'hC: hex2seg = 7'h46;
            4'hD: hex2seg = 7'h21;
            4'hE: hex2seg = 7'h06;
            default: hex2seg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        tick    = en && (presc_q == PW'(REFRESH_DIV - 1));
        last    = (sel_q == SELW'(NUM_DIGITS - 1));
        // fd_q survives en=0 so a deferred frame boundary still happens on resume
        wrap    = fd_q && en;
        presc_d = presc_q;
        sel_d   = sel_q;
        fd_d    = fd_q;
        if (en) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            fd_d    = tick && last;
            if (tick) begin
                sel_d = last ? '0 : sel_q + SELW'(1);
            end
        end

        stg_dig_d = stg_dig_q;
        stg_dp_d  = stg_dp_q;
        stg_blk_d = stg_blk_q;
        if (upd_i) begin
            stg_dig_d = digits_i;
            stg_dp_d  = dp_i;
            stg_blk_d = blank_i;
        end

        shd_dig_d = shd_dig_q;
        shd_dp_d  = shd_dp_q;
        shd_blk_d = shd_blk_q;
        pend_d    = pend_q;
        if (wrap) begin
            pend_d = 1'b0;
            if (upd_i) begin
                shd_dig_d = digits_i;
                shd_dp_d  = dp_i;
                shd_blk_d = blank_i;
            end else if (pend_q) begin
                shd_dig_d = stg_dig_q;
                shd_dp_d  = stg_dp_q;
                shd_blk_d = stg_blk_q;
            end
        end else if (upd_i) begin
            pend_d = 1'b1;
        end

`ifdef SSD_SCAN_DIM_EN
        bright_d = tick ? bright_i : bright_q;
`endif

        // Decode from the next shadow value so a boundary load is seen by the first slot of the new frame
        nib  = shd_dig_d[{sel_q, 2'b00} +: 4];
        lit  = en && (int'(presc_q) >= BLANK_CYC);
`ifdef SSD_SCAN_DIM_EN
        lit  = lit && ((32'(presc_q) << 4) < ((32'(bright_q) + 32'd1) * 32'(REFRESH_DIV)));
`endif
        anode_d = lit ? ~(NUM_DIGITS'(1) << sel_q) : '1;
        seg_d   = shd_blk_d[sel_q] ? 7'h7F : hex2seg(nib);
        dpn_d   = shd_blk_d[sel_q] ? 1'b1 : ~shd_dp_d[sel_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            sel_q     <= '0;
            fd_q      <= 1'b0;
            pend_q    <= 1'b0;
            stg_dig_q <= '0;
            stg_dp_q  <= '0;
            stg_blk_q <= '0;
            shd_dig_q <= '0;
            shd_dp_q  <= '0;
            shd_blk_q <= '1;
            anode_q   <= '1;
            seg_q     <= 7'h7F;
            dpn_q     <= 1'b1;
`ifdef SSD_SCAN_DIM_EN
            bright_q  <= 4'hF;
`endif
        end else begin
            presc_q   <= presc_d;
            sel_q     <= sel_d;
            fd_q      <= fd_d;
            pend_q    <= pend_d;
            stg_dig_q <= stg_dig_d;
            stg_dp_q  <= stg_dp_d;
            stg_blk_q <= stg_blk_d;
            shd_dig_q <= shd_dig_d;
            shd_dp_q  <= shd_dp_d;
            shd_blk_q <= shd_blk_d;
            anode_q   <= anode_d;
            seg_q     <= seg_d;
            dpn_q     <= dpn_d;
`ifdef SSD_SCAN_DIM_EN
            bright_q  <= bright_d;
`endif
        end
    end

    assign upd_pending_o = pend_q;
    assign anode         = anode_q;
    assign seg           = seg_q;
    assign dp_n          = dpn_q;
    assign digit_sel     = sel_q;
    assign frame_done    = fd_q && en;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl (4 digits, 4-cycle slots, 1 blank cycle): expected frame contents are queued when updates are driven and compared per frame.
module tb_ssd_scan_ctrl;

    typedef struct packed {
        logic [27:0] seg;
        logic [3:0]  dpn;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst, en, upd_i;
    logic [15:0] digits_i;
    logic [3:0]  dp_i, blank_i;
    logic        upd_pending_o;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp_n;
    logic [1:0]  digit_sel;
    logic        frame_done;

    int     n_chk = 0;
    int     n_err = 0;
    logic   mon_on = 1'b0;
    frame_t sb_q[$];

    ssd_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(1)) dut (
        .clk(clk), .rst(rst), .en(en), .digits_i(digits_i), .dp_i(dp_i),
        .blank_i(blank_i), .upd_i(upd_i), .upd_pending_o(upd_pending_o),
        .anode(anode), .seg(seg), .dp_n(dp_n), .digit_sel(digit_sel),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[h];
    endfunction

    function automatic frame_t exp_frame(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        frame_t f;
        for (int k = 0; k < 4; k++) begin
            f.seg[k*7 +: 7] = bl[k] ? 7'h7F : hex7(d[k*4 +: 4]);
            f.dpn[k]        = bl[k] ? 1'b1 : ~dp[k];
        end
        return f;
    endfunction

    // Monitor: collect what each lit slot shows during a frame, compare at frame_done
    logic [27:0] rec_seg;
    logic [3:0]  rec_dpn, seen;
    logic        bad;
    always @(negedge clk) begin
        frame_t e;
        int idx;
        if (!mon_on) begin
            seen = '0;
            bad  = 1'b0;
        end else begin
            if (anode != 4'hF) begin
                idx = -1;
                for (int i = 0; i < 4; i++)
                    if (anode == ~(4'b0001 << i)) idx = i;
                if (idx < 0) bad = 1'b1;
                else if (seen[idx] && (rec_seg[idx*7 +: 7] != seg || rec_dpn[idx] != dp_n)) bad = 1'b1;
                else begin
                    seen[idx]           = 1'b1;
                    rec_seg[idx*7 +: 7] = seg;
                    rec_dpn[idx]        = dp_n;
                end
            end
            if (frame_done) begin
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("frm_seen", {28'd0, seen}, 32'hF);
                    check("frm_stable", {31'd0, bad}, 32'd0);
                    check("frm_seg", {4'd0, rec_seg}, {4'd0, e.seg});
                    check("frm_dpn", {28'd0, rec_dpn}, {28'd0, e.dpn});
                end
                seen = '0;
                bad  = 1'b0;
            end
        end
    end

    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 40);
        if (!frame_done) check("fd_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_upd(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        digits_i = d; dp_i = dp; blank_i = bl; upd_i = 1'b1;
        @(negedge clk);
        upd_i = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_anode"}, {28'd0, anode}, 32'hF);
        check({tag, "_seg"}, {25'd0, seg}, 32'h7F);
        check({tag, "_dpn"}, {31'd0, dp_n}, 32'd1);
        check({tag, "_sel"}, {30'd0, digit_sel}, 32'd0);
        check({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
        check({tag, "_pend"}, {31'd0, upd_pending_o}, 32'd0);
    endtask

    initial begin
        logic [3:0] ea;
        rst = 1'b1; en = 1'b1; upd_i = 1'b0; digits_i = '0; dp_i = '0; blank_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        rst = 1'b0;

        // Free scan after reset: blank shadow, slot dark for its first cycle
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            ea = 4'hF;
            if ((k - 1) % 4 != 0) ea[((k - 1) / 4) % 4] = 1'b0;
            check("scan_anode", {28'd0, anode}, {28'd0, ea});
            check("scan_sel", {30'd0, digit_sel}, (k / 4) % 4);
            check("scan_fd", {31'd0, frame_done}, (k % 16 == 0) ? 32'd1 : 32'd0);
            check("scan_seg", {25'd0, seg}, 32'h7F);
        end
        #1;
        mon_on = 1'b1;
        sb_q.push_back(exp_frame(16'h0, 4'h0, 4'hF));

        // Mid-frame update waits for the boundary
        repeat (6) @(negedge clk);
        pulse_upd(16'h1A3F, 4'h0, 4'h0);
        check("pend_set", {31'd0, upd_pending_o}, 32'd1);
        sb_q.push_back(exp_frame(16'h1A3F, 4'h0, 4'h0));
        wait_fd();
        @(negedge clk);
        check("pend_clr", {31'd0, upd_pending_o}, 32'd0);

        // Two updates in one frame: last wins
        repeat (2) @(negedge clk);
        pulse_upd(16'h0000, 4'h0, 4'h0);
        repeat (3) @(negedge clk);
        pulse_upd(16'h8888, 4'h0, 4'h0);
        check("pend_two", {31'd0, upd_pending_o}, 32'd1);
        sb_q.push_back(exp_frame(16'h8888, 4'h0, 4'h0));
        wait_fd();
        wait_fd();

        // Update on the frame_done cycle loads straight into the new frame
        sb_q.push_back(exp_frame(16'h5555, 4'h0, 4'h0));
        pulse_upd(16'h5555, 4'h0, 4'h0);
        check("pend_wrap", {31'd0, upd_pending_o}, 32'd0);

        // Decimal point and per-digit blank
        repeat (3) @(negedge clk);
        pulse_upd(16'h5555, 4'b0100, 4'b0001);
        sb_q.push_back(exp_frame(16'h5555, 4'b0100, 4'b0001));
        wait_fd();
        wait_fd();
        #1;
        mon_on = 1'b0;
        check("sb_drain1", sb_q.size(), 32'd0);

        // en low mid-slot: dark, frozen; resumes with the remaining count
        repeat (2) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("dis_anode", {28'd0, anode}, 32'hF);
            check("dis_sel", {30'd0, digit_sel}, 32'd0);
            check("dis_fd", {31'd0, frame_done}, 32'd0);
        end
        en = 1'b1;
        @(negedge clk);
        check("res_anode0", {28'd0, anode}, 32'hE);
        check("res_sel0", {30'd0, digit_sel}, 32'd0);
        @(negedge clk);
        check("res_anode1", {28'd0, anode}, 32'hE);
        check("res_sel1", {30'd0, digit_sel}, 32'd1);
        @(negedge clk);
        check("res_anode2", {28'd0, anode}, 32'hF);

        // Reset mid-frame discards a pending update
        pulse_upd(16'h7777, 4'hF, 4'h0);
        check("pend_pre_rst", {31'd0, upd_pending_o}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid_rst");
        rst = 1'b0;
        mon_on = 1'b1;
        sb_q.push_back(exp_frame(16'h0, 4'h0, 4'hF));
        sb_q.push_back(exp_frame(16'h0, 4'h0, 4'hF));
        wait_fd();
        wait_fd();
        #1;
        mon_on = 1'b0;
        check("sb_drain2", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
